uart_cal_parser: RTL and testbench
==================================

// Module: uart_cal_parser
// PURPOSE
//   Downstream consumer of the UART receiver in the UART calculator. Takes received
//   ASCII bytes (rx_data/rx_valid) and parses lines of the form "<A><op><B>=".
//   Computes the result and presents it for the formatter/transmit path.
//   A and B are unsigned decimal; op is one of + - *.
// PARAMETERS
//   OPW     16  operand accumulator width, in bits
//   MAXDIG  4   maximum decimal digits per operand; requires 10^MAXDIG-1 < 2^OPW
//   RW      32  result width; fixed at 2*OPW, signed two's complement
// PORTS
//   clk           in   1       system clock, 50 MHz
//   n_rst         in   1       asynchronous active-low reset
//   rx_data       in   8       received byte; sampled only on an accept cycle
//   rx_valid      in   1       byte-valid level from the receiver; may stay high several cycles
//   result        out  RW      signed result; holds until the next result
//   result_valid  out  1       one-cycle pulse; result is new
//   err           out  1       one-cycle pulse; line rejected
//   err_code      out  2       1 = illegal char, 2 = too many digits, 3 = missing operand/op; holds
//   busy          out  1       high whenever the state is not IDLE
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, accA=accB=0, digit count=0, op=0, rx_valid_d=0,
//     result=0, result_valid=0, err=0, err_code=0.
//   Accept cycle: rx_valid=1 and rx_valid_d=0 (rising edge). Exactly one byte per edge.
//   Byte classes: digit 0x30-0x39; op '+' 0x2B, '-' 0x2D, '*' 0x2A; end '=' 0x3D or CR 0x0D;
//     space 0x20 is ignored in every parse state; any other byte is illegal.
//   Digit accumulate: acc <= acc*10 + (byte-0x30), OPW bits. A digit that would be digit
//     MAXDIG+1 of an operand -> error code 2.
//   States:
//     IDLE  digit->OPA, acc A = digit, count=1.
//           op or end -> ERR, code 3. Illegal -> ERR, code 1.
//     OPA   digit->accumulate. op->latch op, OPB0. end->ERR, code 3. Illegal->ERR, code 1.
//     OPB0  digit->OPB, acc B = digit, count=1. op/end->ERR, code 3. Illegal->ERR, code 1.
//     OPB   digit->accumulate. end->CALC. op->ERR, code 3. Illegal->ERR, code 1.
//     CALC  one cycle. Register result, pulse result_valid, go to IDLE.
//           result = A+B, A-B or A*B, operands zero-extended to RW; A-B may go negative.
//     ERR   entered with err pulsed for 1 cycle and err_code set. Discards bytes until end
//           ('=' or CR), then IDLE.
//   Latency: end byte on accept cycle T -> CALC at T+1 -> result/result_valid valid at T+2.
//     Both are high for exactly one cycle; accA/accB are cleared on leaving CALC.
//   An accept cycle that falls in CALC drops that byte. It is unreachable at 115200 baud,
//     where bytes are spaced at 4000 or more clocks.
//   rx_valid already high when reset releases counts as one edge on the first cycle.
//   err and result_valid are never high together.
// TESTING
//   "12+34=" -> one result_valid pulse 2 cycles after '=' accept, result=46; err never high.
//   "100-250=" -> result=32'hFFFFFF6A (-150); " 9999 * 9999 \r" -> result=32'h05F592E1.
//   "12345+1=" -> err pulse, code 2, on the '5' accept; no result_valid.
//     Then "7*6=" -> result=42.
//   "1/2=" -> err code 1; "+3=" -> err code 3; "12=" -> err code 3.
//     Each recovers; the next "2+2=" -> result=4.
//   rx_valid held high 3 cycles per byte while sending "5+5=" -> exactly 4 accepts, result=10.
//   Assert n_rst after "12+" -> all outputs at reset values, busy=0. Then "3+4=" -> result=7.

Source files
------------

// File: rtl/uart_cal_parser.sv
// Line parser for the UART calculator: turns "<A><op><B>=" byte streams into a
// signed result, or an error pulse with a reason code.
module uart_cal_parser #(
  parameter int unsigned OPW    = 16,
  parameter int unsigned MAXDIG = 4,
  parameter int unsigned RW     = 2 * OPW
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [RW-1:0] result,
  output logic          result_valid,
  output logic          err,
  output logic [1:0]    err_code,
  output logic          busy
);

  localparam int unsigned CW = $clog2(MAXDIG + 1);

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;

  localparam logic [1:0] EC_ILLEGAL = 2'd1;
  localparam logic [1:0] EC_DIGITS  = 2'd2;
  localparam logic [1:0] EC_MISSING = 2'd3;

  typedef enum logic [2:0] {IDLE, OPA, OPB0, OPB, CALC, ERR} state_e;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_nxt;
  logic [OPW-1:0]  acc_a_q, acc_a_nxt;
  logic [OPW-1:0]  acc_b_q, acc_b_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            rx_valid_d;

  logic [RW-1:0]   result_nxt;
  logic            result_valid_nxt;
  logic            err_nxt;
  logic [1:0]      err_code_nxt;

  logic            is_dig, is_op, is_end, is_sp;
  logic [3:0]      dig_val;
  logic            accept, take, digit_full;
  logic            bad;
  logic [1:0]      bad_code;
  logic [RW-1:0]   a_ext, b_ext;

  // Byte classification of the current receive byte.
  always_comb begin
    is_dig  = (rx_data >= CH_ZERO) && (rx_data <= CH_NINE);
    is_op   = (rx_data == CH_PLUS) || (rx_data == CH_MINUS) || (rx_data == CH_STAR);
    is_end  = (rx_data == CH_EQ) || (rx_data == CH_CR);
    is_sp   = (rx_data == CH_SP);
    dig_val = rx_data[3:0];
  end

  assign accept     = rx_valid && !rx_valid_d;
  assign take       = accept && !is_sp;
  assign digit_full = (cnt_q == CW'(MAXDIG));
  assign a_ext      = RW'(acc_a_q);
  assign b_ext      = RW'(acc_b_q);

  // Decide whether the byte being taken rejects the line, and why.
  always_comb begin
    bad      = 1'b0;
    bad_code = 2'd0;
    if (take) begin
      case (state_q)
        IDLE, OPB0: begin
          if (!is_dig) begin
            bad      = 1'b1;
            bad_code = (is_op || is_end) ? EC_MISSING : EC_ILLEGAL;
          end
        end
        OPA: begin
          if (is_dig) begin
            if (digit_full) begin
              bad      = 1'b1;
              bad_code = EC_DIGITS;
            end
          end else if (!is_op) begin
            bad      = 1'b1;
            bad_code = is_end ? EC_MISSING : EC_ILLEGAL;
          end
        end
        OPB: begin
          if (is_dig) begin
            if (digit_full) begin
              bad      = 1'b1;
              bad_code = EC_DIGITS;
            end
          end else if (!is_end) begin
            bad      = 1'b1;
            bad_code = is_op ? EC_MISSING : EC_ILLEGAL;
          end
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A rejecting end byte already closes the line, so there is
  // nothing left to discard and the parser returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    if (state_q == CALC) begin
      state_d = IDLE;
    end else if (bad) begin
      state_d = is_end ? IDLE : ERR;
    end else if (take) begin
      case (state_q)
        IDLE: state_d = OPA;
        OPA:  if (is_op) state_d = OPB0;
        OPB0: state_d = OPB;
        OPB:  if (is_end) state_d = CALC;
        ERR:  if (is_end) state_d = IDLE;
        default: ;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    acc_a_nxt        = acc_a_q;
    acc_b_nxt        = acc_b_q;
    cnt_nxt          = cnt_q;
    op_nxt           = op_q;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    err_nxt          = 1'b0;
    err_code_nxt     = err_code;
    if (state_q == CALC) begin
      result_valid_nxt = 1'b1;
      acc_a_nxt        = '0;
      acc_b_nxt        = '0;
      cnt_nxt          = '0;
      case (op_q)
        OP_ADD:  result_nxt = a_ext + b_ext;
        OP_SUB:  result_nxt = a_ext - b_ext;
        OP_MUL:  result_nxt = a_ext * b_ext;
        default: result_nxt = '0;
      endcase
    end else if (bad) begin
      err_nxt      = 1'b1;
      err_code_nxt = bad_code;
      acc_a_nxt    = '0;
      acc_b_nxt    = '0;
      cnt_nxt      = '0;
    end else if (take) begin
      case (state_q)
        IDLE: begin
          acc_a_nxt = OPW'(dig_val);
          cnt_nxt   = CW'(1);
        end
        OPA: begin
          if (is_dig) begin
            acc_a_nxt = acc_a_q * OPW'(10) + OPW'(dig_val);
            cnt_nxt   = cnt_q + CW'(1);
          end else begin
            cnt_nxt = '0;
            case (rx_data)
              CH_PLUS:  op_nxt = OP_ADD;
              CH_MINUS: op_nxt = OP_SUB;
              default:  op_nxt = OP_MUL;
            endcase
          end
        end
        OPB0: begin
          acc_b_nxt = OPW'(dig_val);
          cnt_nxt   = CW'(1);
        end
        OPB: begin
          if (is_dig) begin
            acc_b_nxt = acc_b_q * OPW'(10) + OPW'(dig_val);
            cnt_nxt   = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      cnt_q        <= '0;
      op_q         <= OP_NONE;
      rx_valid_d   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'd0;
      busy         <= 1'b0;
    end else begin
      acc_a_q      <= acc_a_nxt;
      acc_b_q      <= acc_b_nxt;
      cnt_q        <= cnt_nxt;
      op_q         <= op_nxt;
      rx_valid_d   <= rx_valid;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      err          <= err_nxt;
      err_code     <= err_code_nxt;
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cal_parser.sv
// Bench for uart_cal_parser: fixed line table, timing corner sequences and
// random lines checked against a string-level parser model.
module tb_uart_cal_parser;

  typedef logic [7:0] u8_t;
  typedef struct {
    bit          is_err;
    logic [31:0] val;
  } ev_t;
  typedef struct {
    string       line;
    bit          is_err;
    logic [31:0] val;
    int          hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] result;
  logic        result_valid;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  ev_t  evq[$];
  vec_t vecs[$];

  uart_cal_parser #(.OPW(16), .MAXDIG(4), .RW(32)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Collect every output pulse seen between edges.
  always @(negedge clk) begin
    if (n_rst) begin
      ev_t e;
      if (result_valid && err) begin
        n_tests++;
        n_fail++;
        $display("FAIL both_high: result_valid=1 err=1, required never together");
      end
      if (result_valid) begin
        e.is_err = 1'b0;
        e.val    = result;
        evq.push_back(e);
      end
      if (err) begin
        e.is_err = 1'b1;
        e.val    = 32'(err_code);
        evq.push_back(e);
      end
    end
  end

  function automatic bit is_dig(input u8_t c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction
  function automatic bit is_opc(input u8_t c);
    return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A);
  endfunction
  function automatic bit is_endc(input u8_t c);
    return (c == 8'h3D) || (c == 8'h0D);
  endfunction
  function automatic bit is_ill(input u8_t c);
    return !is_dig(c) && !is_opc(c) && !is_endc(c) && (c != 8'h20);
  endfunction

  // Reference: strip spaces, read operand, operator, operand, terminator.
  function automatic void model_line(input u8_t q[$], output bit e, output logic [31:0] v);
    u8_t    t[$];
    longint a = 0;
    longint b = 0;
    int     i = 0;
    int     nd;
    u8_t    op;
    foreach (q[k]) if (q[k] != 8'h20) t.push_back(q[k]);
    e = 1'b1;
    if (!is_dig(t[0])) begin v = is_ill(t[0]) ? 32'd1 : 32'd3; return; end
    nd = 0;
    while (is_dig(t[i])) begin
      if (nd == 4) begin v = 32'd2; return; end
      a = a * 10 + (longint'(t[i]) - 48);
      nd++;
      i++;
    end
    if (!is_opc(t[i])) begin v = is_ill(t[i]) ? 32'd1 : 32'd3; return; end
    op = t[i];
    i++;
    if (!is_dig(t[i])) begin v = is_ill(t[i]) ? 32'd1 : 32'd3; return; end
    nd = 0;
    while (is_dig(t[i])) begin
      if (nd == 4) begin v = 32'd2; return; end
      b = b * 10 + (longint'(t[i]) - 48);
      nd++;
      i++;
    end
    if (!is_endc(t[i])) begin v = is_ill(t[i]) ? 32'd1 : 32'd3; return; end
    e = 1'b0;
    if (op == 8'h2B)      v = 32'(a + b);
    else if (op == 8'h2D) v = 32'(a - b);
    else                  v = 32'(a * b);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic check_event(input string name, input bit exp_err, input logic [31:0] exp_val);
    n_tests++;
    if (evq.size() != 1) begin
      n_fail++;
      $display("FAIL %s: %0d output pulses, required 1 (err=%0d val=%h)",
               name, evq.size(), exp_err, exp_val);
    end else if (evq[0].is_err != exp_err || evq[0].val !== exp_val) begin
      n_fail++;
      $display("FAIL %s: got err=%0d val=%h, required err=%0d val=%h",
               name, evq[0].is_err, evq[0].val, exp_err, exp_val);
    end
    evq.delete();
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic send_byte(input u8_t b, input int hold, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_chars(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) send_byte(u8_t'(s[i]), hold, 2);
  endtask

  task automatic send_str(input string s, input int hold);
    send_chars(s, hold);
    repeat (4) @(negedge clk);
  endtask

  task automatic add_vec(input string l, input bit e, input logic [31:0] v, input int h);
    vec_t x;
    x.line = l; x.is_err = e; x.val = v; x.hold = h;
    vecs.push_back(x);
  endtask

  function automatic u8_t rand_ill();
    u8_t c;
    do c = u8_t'($urandom_range(0, 255)); while (!is_ill(c));
    return c;
  endfunction

  function automatic u8_t rand_op();
    int r = int'($urandom_range(0, 2));
    return (r == 0) ? 8'h2B : (r == 1) ? 8'h2D : 8'h2A;
  endfunction

  task automatic push_operand(inout u8_t q[$]);
    int nd = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(1, 4));
    for (int i = 0; i < nd; i++) q.push_back(u8_t'(32'h30 + $urandom_range(0, 9)));
    if ($urandom_range(0, 3) == 0) q.push_back(8'h20);
  endtask

  task automatic gen_line(output u8_t q[$]);
    int idx;
    int r;
    q = {};
    if ($urandom_range(0, 3) == 0) q.push_back(8'h20);
    push_operand(q);
    q.push_back(rand_op());
    if ($urandom_range(0, 3) == 0) q.push_back(8'h20);
    push_operand(q);
    q.push_back(($urandom_range(0, 1) == 0) ? 8'h3D : 8'h0D);
    idx = int'($urandom_range(0, 32'(q.size() - 2)));
    r   = int'($urandom_range(0, 9));
    if (r == 0)      q[idx] = rand_ill();
    else if (r == 1) q.delete(idx);
    else if (r == 2) q.insert(idx, rand_op());
  endtask

  initial begin
    u8_t         q[$];
    bit          e;
    logic [31:0] v;

    add_vec("12+34=",            1'b0, 32'd46,        1);
    add_vec("100-250=",          1'b0, 32'hFFFFFF6A,  1);
    add_vec(" 9999 * 9999 \015", 1'b0, 32'h05F592E1,  1);
    add_vec("12345+1=",          1'b1, 32'd2,         1);
    add_vec("7*6=",              1'b0, 32'd42,        1);
    add_vec("1/2=",              1'b1, 32'd1,         1);
    add_vec("2+2=",              1'b0, 32'd4,         1);
    add_vec("+3=",               1'b1, 32'd3,         1);
    add_vec("2+2=",              1'b0, 32'd4,         1);
    add_vec("12=",               1'b1, 32'd3,         1);
    add_vec("2+2=",              1'b0, 32'd4,         1);
    add_vec("5+5=",              1'b0, 32'd10,        3);
    add_vec("0000-1=",           1'b0, 32'hFFFFFFFF,  2);
    add_vec("1+23456=",          1'b1, 32'd2,         1);
    add_vec("8*=",               1'b1, 32'd3,         1);

    repeat (3) @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_result_valid", 32'(result_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_err_code", 32'(err_code), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Result latency: CALC the cycle after '=', pulse the cycle after that.
    send_chars("12+34", 1);
    send_byte(8'h3D, 1, 0);
    check("calc_cycle_rv_low", 32'(result_valid), 32'd0);
    check("calc_cycle_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("latency_rv", 32'(result_valid), 32'd1);
    check("latency_result", result, 32'd46);
    check("latency_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rv_one_cycle", 32'(result_valid), 32'd0);
    check("result_holds", result, 32'd46);
    repeat (2) @(negedge clk);
    check_event("latency_event", 1'b0, 32'd46);

    // Error pulse timing on the fifth digit.
    send_chars("1234", 1);
    send_byte(8'h35, 1, 0);
    check("ovf_err_pulse", 32'(err), 32'd1);
    check("ovf_err_code", 32'(err_code), 32'd2);
    check("ovf_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("ovf_err_one_cycle", 32'(err), 32'd0);
    check("ovf_code_holds", 32'(err_code), 32'd2);
    send_str("+1=", 1);
    check_event("ovf_event", 1'b1, 32'd2);

    foreach (vecs[i]) begin
      send_str(vecs[i].line, vecs[i].hold);
      check_event($sformatf("vec%0d", i), vecs[i].is_err, vecs[i].val);
    end

    // Reset in the middle of a line.
    send_chars("12+", 1);
    n_rst = 1'b0;
    #1;
    check("midreset_result", result, 32'd0);
    check("midreset_err_code", 32'(err_code), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_rv_err", 32'({result_valid, err}), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    evq.delete();
    @(negedge clk);
    send_str("3+4=", 1);
    check_event("after_reset", 1'b0, 32'd7);

    // rx_valid already high when reset releases counts as one byte.
    n_rst    = 1'b0;
    rx_data  = 8'h38;
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("held_valid_busy", 32'(busy), 32'd1);
    send_str("+1=", 1);
    check_event("held_valid_event", 1'b0, 32'd9);

    // Random lines against the model.
    for (int n = 0; n < 60; n++) begin
      gen_line(q);
      model_line(q, e, v);
      foreach (q[k]) send_byte(q[k], int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
      repeat (4) @(negedge clk);
      check_event($sformatf("rand%0d", n), e, v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
